// File: rtl/packed_split_pkg.sv
// Shared types for the packed split buffer: lane-forming mode and the stored entry layout.
package packed_split_pkg;

  typedef enum logic {
    MODE_MIRROR = 1'b0,
    MODE_ROTATE = 1'b1
  } mode_e;

  // Entry layout at the default configuration; the buffer declares the same shape from its own parameters.
  localparam int unsigned ENTRY_LANE_W    = 8;
  localparam int unsigned ENTRY_NUM_LANES = 4;

  typedef struct packed {
    logic [ENTRY_NUM_LANES*ENTRY_LANE_W-1:0] pv;
    logic [1:0][ENTRY_LANE_W-1:0]            pa;
  } entry_t;

endpackage

// File: rtl/packed_lane_former.sv
// Combinational lane former: builds the packed word from a seed in mirror or rotate mode.
module packed_lane_former
  import packed_split_pkg::*;
#(
  parameter int LANE_W    = 8,
  parameter int NUM_LANES = 4
) (
  input  logic [LANE_W-1:0]           seed,
  input  mode_e                       mode,
  output logic [NUM_LANES*LANE_W-1:0] pv
);

  function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int s);
    logic [2*LANE_W-1:0] t;
    t = {v, v} << s;
    return t[2*LANE_W-1:LANE_W];
  endfunction

  // Mirror mode alternates seed / ~seed, so lane k equals lane k-2 by construction.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign pv[k*LANE_W +: LANE_W] = (mode == MODE_ROTATE) ? rotl(seed, k % LANE_W) :
                                    ((k % 2) == 0)        ? seed : ~seed;
  end

endmodule

// File: rtl/packed_split_buffer.sv
// Registered FIFO of packed-word entries; each entry leaves as two beats, one per array element.
module packed_split_buffer
  import packed_split_pkg::*;
#(
  parameter int LANE_W    = 8,
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANE_W-1:0]              in_data,
  input  logic [2*LANE_W-1:0]            in_pa,
  input  logic                           in_mode,
  input  logic                           clear,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*LANE_W-1:0]    out_pv,
  output logic [LANE_W-1:0]              out_pa,
  output logic                           out_last,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PV_W = NUM_LANES * LANE_W;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = $clog2(DEPTH);

  typedef struct packed {
    logic [PV_W-1:0]        pv;
    logic [1:0][LANE_W-1:0] pa;
  } buf_entry_t;

  buf_entry_t      mem [DEPTH];
  buf_entry_t      wr_ent_p0;
  buf_entry_t      head;
  logic [PV_W-1:0] pv_p0;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            beat;
  logic            push;
  logic            beat_xfer;
  logic            pop;

  packed_lane_former #(
    .LANE_W    (LANE_W),
    .NUM_LANES (NUM_LANES)
  ) u_former (
    .seed (in_data),
    .mode (mode_e'(in_mode)),
    .pv   (pv_p0)
  );

  always_comb begin
    wr_ent_p0       = '0;
    wr_ent_p0.pv    = pv_p0;
    wr_ent_p0.pa[0] = in_pa[LANE_W-1:0];
    wr_ent_p0.pa[1] = in_pa[2*LANE_W-1:LANE_W];
  end

  assign in_ready  = (count != CW'(DEPTH)) && !rst;
  assign push      = in_valid && in_ready && !clear;
  assign out_valid = (count != '0);
  assign beat_xfer = out_valid && out_ready;
  assign pop       = beat_xfer && beat;

  // Storage carries no reset; outputs are gated by out_valid so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent_p0;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      beat   <= 1'b0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      if (beat_xfer) beat   <= ~beat;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read stage: head entry selected by the read pointer, element by the beat index.
  always_comb begin
    head     = mem[rd_ptr];
    out_pv   = '0;
    out_pa   = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_pv   = head.pv;
      out_pa   = head.pa[beat];
      out_last = beat;
    end
  end

endmodule

// File: tb/tb_packed_split_buffer.sv
// Directed bench for packed_split_buffer at LANE_W=8, NUM_LANES=4, DEPTH=4.
module tb_packed_split_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [15:0] in_pa;
  logic        in_mode;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pv;
  logic [7:0]  out_pa;
  logic        out_last;
  logic [2:0]  count;

  int total    = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  packed_split_buffer #(.LANE_W(8), .NUM_LANES(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pa     (in_pa),
    .in_mode   (in_mode),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pv    (out_pv),
    .out_pa    (out_pa),
    .out_last  (out_last),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mirror(input logic [7:0] d);
    return {~d, d, ~d, d};
  endfunction

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_pv"}, 64'(out_pv), 64'd0);
    check({tag, "_pa"}, 64'(out_pa), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_pa = '0; in_mode = 1'b0;
    clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check_empty("reset");
    check("reset_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0; #1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Mirror-mode entry, consumer always ready
    in_valid = 1'b1; in_data = 8'hA5; in_mode = 1'b0; in_pa = 16'hBEEF; out_ready = 1'b1; #1;
    check("no_fallthrough", 64'(out_valid), 64'd0);
    tick(); in_valid = 1'b0; #1;
    check("m0_valid", 64'(out_valid), 64'd1);
    check("m0_count", 64'(count), 64'd1);
    check("m0_b0_pv", 64'(out_pv), 64'h5AA55AA5);
    check("m0_b0_pa", 64'(out_pa), 64'hEF);
    check("m0_b0_last", 64'(out_last), 64'd0);
    tick();
    check("m0_b1_pv", 64'(out_pv), 64'h5AA55AA5);
    check("m0_b1_pa", 64'(out_pa), 64'hBE);
    check("m0_b1_last", 64'(out_last), 64'd1);
    tick();
    check_empty("m0_drained");

    // Rotate-mode entry with a stalled consumer
    in_valid = 1'b1; in_data = 8'hA5; in_mode = 1'b1; in_pa = 16'h1234; out_ready = 1'b0;
    tick(); in_valid = 1'b0; #1;
    check("m1_pv", 64'(out_pv), 64'h2D964BA5);
    check("m1_b0_pa", 64'(out_pa), 64'h34);
    tick();
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_pv", 64'(out_pv), 64'h2D964BA5);
    check("stall_pa", 64'(out_pa), 64'h34);
    check("stall_last", 64'(out_last), 64'd0);
    out_ready = 1'b1;
    tick();
    check("m1_b1_pa", 64'(out_pa), 64'h12);
    check("m1_b1_last", 64'(out_last), 64'd1);
    tick();
    check("m1_drained", 64'(count), 64'd0);

    // Five pushes into a four-deep FIFO, then drain in order
    out_ready = 1'b0; in_mode = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_pa = {8'(8'h10 + i), 8'(8'h20 + i)}; #1;
      if (i == 5) check("full_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0; #1;
    check("full_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d_b0_pv", i), 64'(out_pv), 64'(mirror(8'(i))));
      check($sformatf("drain%0d_b0_pa", i), 64'(out_pa), 64'(8'h20 + i));
      check($sformatf("drain%0d_b0_last", i), 64'(out_last), 64'd0);
      tick();
      check($sformatf("drain%0d_b1_pa", i), 64'(out_pa), 64'(8'h10 + i));
      check($sformatf("drain%0d_b1_last", i), 64'(out_last), 64'd1);
      tick();
    end
    check("fifth_not_stored", 64'(out_valid), 64'd0);

    // Full FIFO, beat-1 pop with a simultaneous push attempt
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i); in_pa = 16'h0000;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 8'h77; in_pa = 16'h7766; #1;
    check("fullpop_in_ready", 64'(in_ready), 64'd0);
    check("fullpop_last", 64'(out_last), 64'd1);
    tick();
    check("fullpop_count", 64'(count), 64'd3);
    check("fullpop_next_ready", 64'(in_ready), 64'd1);
    check("fullpop_head_pv", 64'(out_pv), 64'(mirror(8'h42)));
    tick();
    check("push_after_pop_count", 64'(count), 64'd4);
    in_valid = 1'b0; out_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0; #1;
    check_empty("clear_full");

    // Clear while beat 1 is stalled, with a push offered in the clear cycle
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = (i == 0) ? 8'h11 : 8'h22; in_pa = 16'h0102;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; #1;
    check("pre_clear_last", 64'(out_last), 64'd1);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    tick();
    clear = 1'b0; in_valid = 1'b0; #1;
    check_empty("clear_mid");
    in_valid = 1'b1; in_data = 8'h55; in_pa = 16'hABCD;
    tick(); in_valid = 1'b0; #1;
    check("after_clear_pa", 64'(out_pa), 64'hCD);
    check("after_clear_last", 64'(out_last), 64'd0);

    // Same scenario with reset instead of clear
    in_valid = 1'b1; in_data = 8'h66; in_pa = 16'h0304;
    tick(); in_valid = 1'b0;
    check("pre_rst_count", 64'(count), 64'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; #1;
    check("pre_rst_last", 64'(out_last), 64'd1);
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; #1;
    check_empty("rst_mid");
    in_valid = 1'b1; in_data = 8'h99; in_pa = 16'hCAFE;
    tick(); in_valid = 1'b0; #1;
    check("after_rst_pv", 64'(out_pv), 64'(mirror(8'h99)));
    check("after_rst_pa", 64'(out_pa), 64'hFE);
    check("after_rst_last", 64'(out_last), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/packed_split_buffer.md
PACKED_SPLIT_BUFFER -- requirements
Module: packed_split_buffer

Interface
REQ-001 SHALL have parameter LANE_W, default 8, bits per lane (>=2).
REQ-002 SHALL have parameter NUM_LANES, default 4, lanes in the packed word (even, >=2).
REQ-003 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-004 clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  producer offers an entry.
REQ-007 in_ready  output  1  block accepts an entry this cycle.
REQ-008 in_data  input  LANE_W  lane seed value.
REQ-009 in_pa  input  2*LANE_W  two-byte array payload; low half is element 0.
REQ-010 in_mode  input  1  lane-forming mode: 0 mirror, 1 rotate.
REQ-011 clear  input  1  synchronous flush of all stored entries.
REQ-012 out_valid  output  1  output beat valid.
REQ-013 out_ready  input  1  consumer takes the beat.
REQ-014 out_pv  output  NUM_LANES*LANE_W  packed word of the head entry.
REQ-015 out_pa  output  LANE_W  array element of the current beat.
REQ-016 out_last  output  1  high on the second (final) beat of an entry.
REQ-017 count  output  $clog2(DEPTH+1)  number of stored entries.

Function
REQ-018 Handshake: a push SHALL occur when in_valid && in_ready; a beat SHALL transfer when out_valid && out_ready.
REQ-019 Mode 0 SHALL form lane0 = in_data, lane1 = ~in_data, and lane k = lane k-2 for k>=2; lane k occupies bits [k*LANE_W +: LANE_W].
REQ-020 Mode 1 SHALL form lane k = in_data rotated left by (k mod LANE_W) bits.
REQ-021 Each pushed entry SHALL store the formed packed word plus in_pa split into element 0 = in_pa[LANE_W-1:0] and element 1 = in_pa[2*LANE_W-1:LANE_W].
REQ-022 The FIFO SHALL be registered with no fall-through: an entry pushed at edge N SHALL raise out_valid no earlier than the cycle after edge N.
REQ-023 Each entry SHALL be output as two beats: beat 0 out_pa = element 0 with out_last=0; beat 1 out_pa = element 1 with out_last=1.
REQ-024 out_pv SHALL hold the head packed word on both beats.
REQ-025 The entry SHALL pop only on a beat-1 transfer; a beat-0 transfer SHALL only advance the beat index.
REQ-026 out_valid, out_pv, out_pa, and out_last SHALL hold stable while out_valid && !out_ready.
REQ-027 When the FIFO is empty, out_valid, out_pv, out_pa, and out_last SHALL all be 0.
REQ-028 in_ready SHALL equal (count != DEPTH) && !rst; when full, no push SHALL occur even if a pop happens in the same cycle.
REQ-029 A simultaneous push and pop (not full) SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-030 clear SHALL take priority over push and pop: next cycle count=0, beat index=0, out_valid=0; in the clear cycle any push is discarded.

Reset
REQ-031 In the cycle after rst is sampled high: count=0, pointers=0, beat index=0, out_valid=0, out_pv=0, out_pa=0, out_last=0.
REQ-032 rst SHALL override clear, push, and pop, and mid-entry assertion SHALL discard a partially sent entry.
REQ-033 Storage array contents SHALL need no reset, provided that no unreset data reaches the outputs.

Structure
REQ-034 A shared package packed_split_pkg SHALL hold the mode enum (MODE_MIRROR, MODE_ROTATE) and a parametrisable entry struct (packed word + 2-element array).
REQ-035 Lane forming SHALL be a combinational sub-module packed_lane_former(LANE_W, NUM_LANES) instantiated once on the write path.

Verification (LANE_W=8, NUM_LANES=4, DEPTH=4)
REQ-036 Push in_data=8'hA5, mode 0, in_pa=16'hBEEF, out_ready=1 -> beat0 out_pv=32'h5AA55AA5, out_pa=8'hEF, out_last=0; beat1 out_pa=8'hBE, out_last=1.
REQ-037 Push in_data=8'hA5, mode 1 -> out_pv=32'h2D964BA5.
REQ-038 out_ready=0, five pushes -> count=4, in_ready=0 after the fourth push, and the fifth is not stored; draining yields entries 1-4 in order as 8 beats.
REQ-039 Full FIFO, beat-1 pop with in_valid=1 in the same cycle -> no push that cycle; count=3, then a push the next cycle -> count=4.
REQ-040 Two entries stored, clear pulsed while beat 1 is stalled -> next cycle count=0, out_valid=0, all outputs 0; rst mid-entry gives the identical result.
